// File: rtl/note_voice.sv
// Single-voice tone generator: 16-bit phase accumulator driven by a note
// increment table, square wave scaled by an attack/sustain/release envelope.
module note_voice #(
  parameter int unsigned ENV_DIV  = 10,
  parameter int unsigned ENV_STEP = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] note,
  output logic [7:0] sample,
  output logic       active,
  output logic [7:0] env_level
);

  localparam int unsigned PRE_W = (ENV_DIV > 2) ? $clog2(ENV_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(ENV_DIV - 1);
  localparam logic [8:0] STEP9 = 9'(ENV_STEP);
  localparam logic [7:0] STEP8 = 8'(ENV_STEP);

  typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} state_t;

  state_t           state, state_d;
  logic [3:0]       note_q, note_d;
  logic [7:0]       amp, amp_d;
  logic [15:0]      phase, phase_d;
  logic [PRE_W-1:0] pre, pre_d;

  logic        change_c;
  logic        tick_c;
  logic [15:0] inc_c;
  logic [8:0]  amp_sum_c;
  logic [7:0]  amp_up_c;
  logic [7:0]  amp_dn_c;

  // Per-note phase increment for a 10 kHz sample rate
  always_comb begin
    inc_c = 16'd0;
    case (note_q)
      4'd1:  inc_c = 16'd1715;
      4'd2:  inc_c = 16'd1817;
      4'd3:  inc_c = 16'd1925;
      4'd4:  inc_c = 16'd2039;
      4'd5:  inc_c = 16'd2160;
      4'd6:  inc_c = 16'd2289;
      4'd7:  inc_c = 16'd2425;
      4'd8:  inc_c = 16'd2569;
      4'd9:  inc_c = 16'd2722;
      4'd10: inc_c = 16'd2884;
      4'd11: inc_c = 16'd3055;
      4'd12: inc_c = 16'd3237;
      4'd13: inc_c = 16'd3429;
      4'd14: inc_c = 16'd3633;
      4'd15: inc_c = 16'd3849;
      default: inc_c = 16'd0;
    endcase
  end

  // Change detection, envelope tick and saturating amplitude steps
  always_comb begin
    change_c  = (note != note_q);
    tick_c    = ((state == ATTACK) || (state == RELEASE)) && (pre == PRE_MAX);
    amp_sum_c = {1'b0, amp} + STEP9;
    amp_up_c  = (amp_sum_c >= 9'd255) ? 8'd255 : amp_sum_c[7:0];
    amp_dn_c  = (amp <= STEP8) ? 8'd0 : (amp - STEP8);
  end

  // Next-state logic; a note change that acts beats an envelope tick
  always_comb begin
    state_d = state;
    note_d  = note_q;
    amp_d   = amp;
    phase_d = phase;
    pre_d   = pre;
    if (state != IDLE) begin
      phase_d = phase + inc_c;
    end
    case (state)
      IDLE: begin
        if (change_c && (note != 4'd0)) begin
          state_d = ATTACK;
          note_d  = note;
          phase_d = 16'd0;
          amp_d   = 8'd0;
          pre_d   = '0;
        end
      end
      default: begin
        if (change_c && (note != 4'd0)) begin
          // Retrigger keeps phase and amplitude for a click-free restart
          state_d = ATTACK;
          note_d  = note;
          pre_d   = '0;
        end else if (change_c && (state != RELEASE)) begin
          // Note released; note_q keeps the pitch for the release tail
          state_d = RELEASE;
          pre_d   = '0;
        end else if (state != SUSTAIN) begin
          if (tick_c) begin
            pre_d = '0;
            if (state == ATTACK) begin
              amp_d = amp_up_c;
              if (amp_up_c == 8'd255) state_d = SUSTAIN;
            end else begin
              amp_d = amp_dn_c;
              if (amp_dn_c == 8'd0) begin
                state_d = IDLE;
                phase_d = 16'd0;
              end
            end
          end else begin
            pre_d = pre + PRE_W'(1);
          end
        end
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      note_q <= 4'd0;
      amp    <= 8'd0;
      phase  <= 16'd0;
      pre    <= '0;
    end else begin
      state  <= state_d;
      note_q <= note_d;
      amp    <= amp_d;
      phase  <= phase_d;
      pre    <= pre_d;
    end
  end

  assign sample    = phase[15] ? amp : 8'd0;
  assign env_level = amp;
  assign active    = (state != IDLE);

endmodule

// File: tb/tb_note_voice.sv
// Self-checking bench for note_voice: default instance plus a fast,
// saturating-envelope instance (ENV_STEP=200, ENV_DIV=2).
module tb_note_voice;

  logic       clk;
  logic       rst;
  logic [3:0] note;
  logic [3:0] note2;
  logic [7:0] sample, env_level, sample2, env_level2;
  logic       active, active2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  smp;
    logic [7:0]  amp;
    logic        act;
    logic [15:0] ph;
  } exp_t;

  exp_t sb[$];

  note_voice u_dut (
    .clk(clk), .rst(rst), .note(note),
    .sample(sample), .active(active), .env_level(env_level)
  );

  note_voice #(.ENV_DIV(2), .ENV_STEP(200)) u_sat (
    .clk(clk), .rst(rst), .note(note2),
    .sample(sample2), .active(active2), .env_level(env_level2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected envelope/phase after edge n of a note started at edge 0
  function automatic exp_t attack_exp(int n, int inc);
    exp_t e;
    int a;
    a = (n / 10) * 8;
    if (a > 255) a = 255;
    e.amp = 8'(a);
    e.ph  = 16'(n * inc);
    e.act = 1'b1;
    e.smp = e.ph[15] ? e.amp : 8'd0;
    return e;
  endfunction

  task automatic do_reset();
    note  = 4'd0;
    note2 = 4'd0;
    rst   = 1'b1;
    step();
    rst   = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    note  = 4'd10;
    note2 = 4'd10;
    for (int i = 0; i < 53; i++) begin
      if (i == 3) begin
        rst   = 1'b0;
        note  = 4'd0;
        note2 = 4'd0;
      end
      step();
      checks++;
      if ({sample, env_level, active, sample2, env_level2, active2} !== 34'd0) begin
        errors++;
        $display("FAIL reset cyc %0d: got smp=%0d lvl=%0d act=%0d smp2=%0d lvl2=%0d act2=%0d expected all 0",
                 i, sample, env_level, active, sample2, env_level2, active2);
      end
    end
  endtask

  // Attack from rest, then sustain with a pitch-period measurement
  task automatic test_attack(output int n_end);
    exp_t e, got;
    int rises;
    logic prev;
    note = 4'd10;
    for (int n = 0; n <= 330; n++) begin
      step();
      sb.push_back(attack_exp(n, 2884));
      e = sb.pop_front();
      got.smp = sample; got.amp = env_level; got.act = active; got.ph = u_dut.phase;
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL attack edge %0d: got smp=%0d lvl=%0d act=%0d ph=%0d expected smp=%0d lvl=%0d act=%0d ph=%0d",
                 n, got.smp, got.amp, got.act, got.ph, e.smp, e.amp, e.act, e.ph);
      end
    end
    rises = 0;
    prev  = (sample != 8'd0);
    for (int n = 331; n <= 2600; n++) begin
      step();
      sb.push_back(attack_exp(n, 2884));
      e = sb.pop_front();
      if ((sample != 8'd0) && !prev) rises++;
      prev = (sample != 8'd0);
      if ((n % 100) == 0) begin
        checks++;
        if ({sample, env_level, active, u_dut.phase} !== {e.smp, e.amp, e.act, e.ph}) begin
          errors++;
          $display("FAIL sustain edge %0d: got smp=%0d lvl=%0d ph=%0d expected smp=%0d lvl=%0d ph=%0d",
                   n, sample, env_level, u_dut.phase, e.smp, e.amp, e.ph);
        end
      end
    end
    // 2270 cycles at a 22.7-cycle period
    checks++;
    if (rises < 98 || rises > 101) begin
      errors++;
      $display("FAIL pitch period: got %0d rises in 2270 cycles expected 98..101", rises);
    end
    n_end = 2600;
  endtask

  task automatic test_release(input int n_start);
    exp_t e;
    int t, a, n;
    note = 4'd0;
    for (int k = 0; k <= 340; k++) begin
      step();
      n = n_start + 1 + k;
      t = k / 10;
      a = 255 - 8 * t;
      if (a < 0) a = 0;
      e.amp = 8'(a);
      e.act = (t < 32);
      e.ph  = e.act ? 16'(n * 2884) : 16'd0;
      e.smp = e.ph[15] ? e.amp : 8'd0;
      sb.push_back(e);
      e = sb.pop_front();
      checks++;
      if ({sample, env_level, active, u_dut.phase} !== {e.smp, e.amp, e.act, e.ph}) begin
        errors++;
        $display("FAIL release k=%0d: got smp=%0d lvl=%0d act=%0d ph=%0d expected smp=%0d lvl=%0d act=%0d ph=%0d",
                 k, sample, env_level, active, u_dut.phase, e.smp, e.amp, e.act, e.ph);
      end
    end
  endtask

  task automatic test_retrigger();
    exp_t e;
    do_reset();
    note = 4'd10;
    for (int n = 0; n <= 160; n++) begin
      step();
      sb.push_back(attack_exp(n, 2884));
      e = sb.pop_front();
      if (n == 160 || n == 80) begin
        checks++;
        if ({env_level, u_dut.phase} !== {e.amp, e.ph}) begin
          errors++;
          $display("FAIL retrig pre edge %0d: got lvl=%0d ph=%0d expected lvl=%0d ph=%0d",
                   n, env_level, u_dut.phase, e.amp, e.ph);
        end
      end
    end
    note = 4'd1;
    for (int j = 1; j <= 25; j++) begin
      step();
      e.amp = 8'(128 + 8 * ((j - 1) / 10));
      e.ph  = 16'(161 * 2884 + (j - 1) * 1715);
      e.act = 1'b1;
      e.smp = e.ph[15] ? e.amp : 8'd0;
      sb.push_back(e);
      e = sb.pop_front();
      checks++;
      if ({sample, env_level, active, u_dut.phase} !== {e.smp, e.amp, e.act, e.ph}) begin
        errors++;
        $display("FAIL retrig j=%0d: got smp=%0d lvl=%0d ph=%0d expected smp=%0d lvl=%0d ph=%0d",
                 j, sample, env_level, u_dut.phase, e.smp, e.amp, e.ph);
      end
    end
  endtask

  task automatic test_saturation();
    logic [7:0] ea;
    logic       ec;
    do_reset();
    note2 = 4'd5;
    for (int k = 0; k < 10; k++) begin
      step();
      ea = (k < 2) ? 8'd0 : ((k < 4) ? 8'd200 : 8'd255);
      checks++;
      if ({env_level2, active2} !== {ea, 1'b1}) begin
        errors++;
        $display("FAIL sat attack k=%0d: got lvl=%0d act=%0d expected lvl=%0d act=1",
                 k, env_level2, active2, ea);
      end
    end
    note2 = 4'd0;
    for (int k = 0; k < 8; k++) begin
      step();
      ea = (k < 2) ? 8'd255 : ((k < 4) ? 8'd55 : 8'd0);
      ec = (k < 4);
      checks++;
      if ({env_level2, active2} !== {ea, ec}) begin
        errors++;
        $display("FAIL sat release k=%0d: got lvl=%0d act=%0d expected lvl=%0d act=%0d",
                 k, env_level2, active2, ea, ec);
      end
    end
    checks++;
    if ({sample2, u_sat.phase} !== 24'd0) begin
      errors++;
      $display("FAIL sat idle: got smp=%0d ph=%0d expected 0 0", sample2, u_sat.phase);
    end
  endtask

  task automatic test_note15();
    logic [15:0] ep;
    do_reset();
    note = 4'd15;
    for (int n = 0; n <= 5; n++) begin
      step();
      ep = 16'(n * 3849);
      checks++;
      if (u_dut.phase !== ep) begin
        errors++;
        $display("FAIL note15 edge %0d: got ph=%0d expected %0d", n, u_dut.phase, ep);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    note = 4'd10;
    repeat (331) step();
    checks++;
    if ({env_level, active} !== {8'd255, 1'b1}) begin
      errors++;
      $display("FAIL async pre: got lvl=%0d act=%0d expected 255 1", env_level, active);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({sample, env_level, active, u_dut.phase} !== 33'd0) begin
      errors++;
      $display("FAIL async reset: got smp=%0d lvl=%0d act=%0d ph=%0d expected 0",
               sample, env_level, active, u_dut.phase);
    end
    note = 4'd0;
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    int n_end;
    rst   = 1'b1;
    note  = 4'd0;
    note2 = 4'd0;
    test_reset();
    test_attack(n_end);
    test_release(n_end);
    test_retrigger();
    test_saturation();
    test_note15();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
